// File: rtl/aer_handshake_ctrl.sv
// Receiver-side 4-phase handshake sequencer for the DAVIS240C AER port.
// Optional event timestamping is enabled by defining AER_TIMESTAMP_EN.
module aer_handshake_ctrl #(
  parameter int                DATA_W      = 9,
  parameter logic [DATA_W-1:0] INV_MASK    = 9'b011000000,
  parameter int                SYNC_STAGES = 2,
  parameter int                SETTLE_CYC  = 2,
  parameter int                ACK_MIN_CYC = 1
`ifdef AER_TIMESTAMP_EN
  ,
  parameter int                TS_W        = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              aer_req_n,
  input  logic [DATA_W-1:0] aer_data,
  output logic              aer_ack_n,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [DATA_W-1:0] ev_data,
  output logic [15:0]       ev_count,
  output logic [7:0]        glitch_cnt,
  output logic              busy
`ifdef AER_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]   ev_ts
`endif
);

  localparam int CNT_MAX = (SETTLE_CYC > ACK_MIN_CYC) ? SETTLE_CYC : ACK_MIN_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ACK_LOAD    = CNT_W'(ACK_MIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_OFFER   = 3'd2,
    ST_ACK     = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   req_s;
  logic                   latch_s;
  logic                   accept_s;
  logic                   glitch_s;
  logic                   valid_nxt_s;
  logic                   ack_n_nxt_s;
  logic                   busy_nxt_s;

  assign req_s = sync_r[SYNC_STAGES-1];

  // REQ synchroniser; resets to the deasserted level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], aer_req_n};
    end
  end

  // State and shared settle/ack-hold counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (en && !req_s) begin
          state_nxt_s = ST_SETTLE;
          cnt_nxt_s   = SETTLE_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (req_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_OFFER;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_OFFER: begin
        if (ev_ready) begin
          state_nxt_s = ST_ACK;
          cnt_nxt_s   = ACK_LOAD;
        end else begin
          state_nxt_s = ST_OFFER;
        end
      end
      ST_ACK: begin
        // ACK is only released once the minimum hold has elapsed and the sensor dropped REQ
        if (cnt_r != CNT_ZERO) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else if (req_s) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_ACK;
        end
      end
      ST_RELEASE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode: event strobes and next values of the registered outputs
  always_comb begin
    latch_s     = (state_r == ST_SETTLE) && !req_s && (cnt_r == CNT_ZERO);
    accept_s    = (state_r == ST_OFFER) && ev_ready;
    glitch_s    = (state_r == ST_SETTLE) && req_s;
    valid_nxt_s = (state_nxt_s == ST_OFFER);
    ack_n_nxt_s = (state_nxt_s != ST_ACK);
    busy_nxt_s  = (state_nxt_s != ST_IDLE);
  end

  // Registered outputs and event/glitch counters
  always_ff @(posedge clk) begin
    if (rst) begin
      aer_ack_n  <= 1'b1;
      ev_valid   <= 1'b0;
      ev_data    <= {DATA_W{1'b0}};
      ev_count   <= 16'd0;
      glitch_cnt <= 8'd0;
      busy       <= 1'b0;
    end else begin
      aer_ack_n <= ack_n_nxt_s;
      ev_valid  <= valid_nxt_s;
      busy      <= busy_nxt_s;
      if (latch_s) begin
        ev_data <= aer_data ^ INV_MASK;
      end else begin
        ev_data <= ev_data;
      end
      if (accept_s) begin
        ev_count <= ev_count + 16'd1;
      end else begin
        ev_count <= ev_count;
      end
      if (glitch_s && (glitch_cnt != 8'hFF)) begin
        glitch_cnt <= glitch_cnt + 8'd1;
      end else begin
        glitch_cnt <= glitch_cnt;
      end
    end
  end

`ifdef AER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_r;

  // Free-running timestamp, captured alongside the event data
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_r  <= {TS_W{1'b0}};
      ev_ts <= {TS_W{1'b0}};
    end else begin
      ts_r <= ts_r + {{(TS_W-1){1'b0}}, 1'b1};
      if (latch_s) begin
        ev_ts <= ts_r;
      end else begin
        ev_ts <= ev_ts;
      end
    end
  end
`endif

endmodule

// File: tb/tb_aer_handshake_ctrl.sv
// Self-checking bench for aer_handshake_ctrl: vector table, corner-case sequences
// and a randomized sensor/consumer run checked against a transaction scoreboard.
module tb_aer_handshake_ctrl;

  localparam logic [8:0] MASK = 9'h0C0;

  logic       clk = 1'b0;
  logic       rst, en, aer_req_n, ev_ready;
  logic [8:0] aer_data, ev_data;
  logic       aer_ack_n, ev_valid, busy;
  logic [15:0] ev_count;
  logic [7:0]  glitch_cnt;
`ifdef AER_TIMESTAMP_EN
  logic [31:0] ev_ts;
  logic [31:0] prev_ts;
  int          prev_cyc;
  bit          have_prev = 1'b0;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int model_cnt = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  aer_handshake_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .aer_req_n  (aer_req_n),
    .aer_data   (aer_data),
    .aer_ack_n  (aer_ack_n),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_data    (ev_data),
    .ev_count   (ev_count),
    .glitch_cnt (glitch_cnt),
    .busy       (busy)
`ifdef AER_TIMESTAMP_EN
    ,
    .ev_ts      (ev_ts)
`endif
  );

  typedef struct {
    logic [8:0] data;
    int         ready_dly;
    int         hold;
    logic [8:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ack_high(input string name, input int exp_n);
    int n = 0;
    while (aer_ack_n == 1'b0 && n < 20) begin
      step();
      n++;
    end
    check(name, n, exp_n);
  endtask

  // One full handshake with a fixed data word, backpressure length and REQ hold time
  task automatic run_event(input logic [8:0] d, input int rdly, input int hold, input logic [8:0] exp_d);
    aer_data  = d;
    aer_req_n = 1'b0;
    ev_ready  = 1'b0;
    repeat (4) step();
    check("latency_pre", ev_valid, 1'b0);
    step();
    check("latency", ev_valid, 1'b1);
    check("ev_data", ev_data, exp_d);
`ifdef AER_TIMESTAMP_EN
    if (have_prev) check("ts_delta", ev_ts - prev_ts, 32'(cyc - prev_cyc));
    prev_ts   = ev_ts;
    prev_cyc  = cyc;
    have_prev = 1'b1;
`endif
    for (int i = 0; i < rdly; i++) begin
      step();
      check("backpressure", {ev_valid, aer_ack_n, ev_data}, {1'b1, 1'b1, exp_d});
    end
    ev_ready = 1'b1;
    step();
    model_cnt++;
    check("ack_latency", {ev_valid, aer_ack_n}, 2'b00);
    check("ev_count", ev_count, model_cnt);
    ev_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      check("ack_hold", aer_ack_n, 1'b0);
    end
    aer_req_n = 1'b1;
    aer_data  = 9'(~d);
    wait_ack_high("ack_release", 3);
    step();
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    int phase, dly, wait_cyc, it;
    bit accepted, acc, vprev;
    logic [8:0] dprev;

    vecs[0] = '{9'h1C5, 0, 4, 9'h105};
    vecs[1] = '{9'h000, 3, 0, 9'h0C0};
    vecs[2] = '{9'h1FF, 20, 1, 9'h13F};
    vecs[3] = '{9'h0C0, 1, 2, 9'h000};
    vecs[4] = '{9'h0AA, 0, 0, 9'h06A};
    vecs[5] = '{9'h155, 7, 3, 9'h195};

    rst = 1'b1; en = 1'b1; aer_req_n = 1'b1; aer_data = 9'h000; ev_ready = 1'b0;
    step(); step();
    check("reset_outputs", {aer_ack_n, ev_valid, busy}, 3'b100);
    check("reset_data", ev_data, 9'h000);
    check("reset_counters", {ev_count, glitch_cnt}, 24'h0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++)
      run_event(vecs[v].data, vecs[v].ready_dly, vecs[v].hold, vecs[v].exp_data);

    // Glitch: two-cycle REQ pulse is too short to be latched
    aer_req_n = 1'b0; aer_data = 9'h1C5;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) aer_req_n = 1'b1;
      step();
      check("glitch_quiet", {ev_valid, aer_ack_n}, 2'b01);
    end
    check("glitch_one", glitch_cnt, 8'd1);
    check("glitch_no_event", ev_count, model_cnt);
    for (int p = 0; p < 256; p++) begin
      aer_req_n = 1'b0;
      step();
      aer_req_n = 1'b1;
      repeat (4) step();
      if (p == 199) check("glitch_mid", glitch_cnt, 8'd201);
    end
    check("glitch_sat", glitch_cnt, 8'hFF);

    // en=0 holds the block in IDLE while REQ is low
    en = 1'b0; aer_req_n = 1'b0; aer_data = 9'h1C5;
    for (int i = 0; i < 10; i++) begin
      step();
      check("en0_idle", {busy, ev_valid, aer_ack_n}, 3'b001);
    end
    en = 1'b1;
    step(); step();
    check("en1_pre", ev_valid, 1'b0);
    step();
    check("en1_valid", {ev_valid, ev_data}, {1'b1, 9'h105});
    en = 1'b0;
    repeat (3) step();
    check("en0_offer_hold", {ev_valid, aer_ack_n, ev_data}, {1'b1, 1'b1, 9'h105});
    ev_ready = 1'b1;
    step();
    model_cnt++;
    check("en0_offer_ack", {ev_valid, aer_ack_n}, 2'b00);
    check("en0_offer_count", ev_count, model_cnt);
    ev_ready = 1'b0; aer_req_n = 1'b1;
    wait_ack_high("en0_release", 3);
    step();
    aer_req_n = 1'b0;
    repeat (6) step();
    check("en0_parked", {busy, ev_valid}, 2'b00);
    aer_req_n = 1'b1; en = 1'b1;
    repeat (3) step();

    // Randomized sensor and consumer against an in-order scoreboard
    phase = 0; dly = 0; wait_cyc = 0; accepted = 1'b0; it = 0;
    while ((it < 4000 || phase != 0) && it < 5000) begin
      acc = ev_valid & ev_ready; dprev = ev_data; vprev = ev_valid;
      step();
      it++;
      if (acc) begin
        if (exp_q.size() == 0) check("rnd_spurious", 32'(exp_q.size()), 32'd1);
        else check("rnd_data", dprev, exp_q.pop_front());
        model_cnt++;
        accepted = 1'b1;
        check("rnd_ack_lat", {ev_valid, aer_ack_n}, 2'b00);
      end else if (vprev) begin
        check("rnd_hold", {ev_valid, ev_data}, {1'b1, dprev});
      end
      check("rnd_count", ev_count, 16'(model_cnt));
      if (phase == 1 && !accepted) check("rnd_early_ack", aer_ack_n, 1'b1);
      case (phase)
        0: begin
          if (dly == 0) begin
            aer_data  = 9'($urandom);
            aer_req_n = 1'b0;
            exp_q.push_back(aer_data ^ MASK);
            accepted  = 1'b0;
            wait_cyc  = 0;
            phase     = 1;
          end else begin
            dly--;
          end
        end
        1: begin
          wait_cyc++;
          if (aer_ack_n == 1'b0) begin
            aer_req_n = 1'b1;
            aer_data  = 9'($urandom);
            phase     = 2;
          end else if (wait_cyc > 300) begin
            check("rnd_timeout", aer_ack_n, 1'b0);
            break;
          end
        end
        default: begin
          if (aer_ack_n == 1'b1) begin
            phase = 0;
            dly   = $urandom_range(0, 4);
          end
        end
      endcase
      ev_ready = ($urandom_range(0, 3) != 0);
    end
    check("rnd_drain", 32'(exp_q.size()), 32'd0);
    check("rnd_glitch", glitch_cnt, 8'hFF);
    ev_ready = 1'b0; aer_req_n = 1'b1;
    repeat (3) step();

    // Reset while ACK is asserted; REQ still low is re-sampled as a fresh event
    aer_data = 9'h0AA; aer_req_n = 1'b0; ev_ready = 1'b1;
    begin
      int n = 0;
      while (aer_ack_n == 1'b1 && n < 12) begin
        step();
        n++;
      end
    end
    check("rst_pre_ack", aer_ack_n, 1'b0);
    rst = 1'b1; ev_ready = 1'b0;
    step();
    check("rst_mid_outputs", {aer_ack_n, ev_valid, busy}, 3'b100);
    check("rst_mid_counters", {ev_count, glitch_cnt}, 24'h0);
    rst = 1'b0;
    model_cnt = 0;
    repeat (4) step();
    check("rst_resample_pre", ev_valid, 1'b0);
    step();
    check("rst_resample", {ev_valid, ev_data}, {1'b1, 9'h06A});
    ev_ready = 1'b1;
    step();
    model_cnt++;
    check("rst_resample_count", ev_count, model_cnt);
    ev_ready = 1'b0; aer_req_n = 1'b1;
    wait_ack_high("rst_release", 3);
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
